mp_ooo_sweep_sram: RTL and testbench

Parametrised single-port (1RW) SRAM behavioural model for the mp_ooo caches. It is the successor to the fixed 16x24 tag array. Over the old array it adds:
- configurable width and depth;
- a per-slice write mask;
- a hardware initialisation and flush sweep that writes INIT_VALUE to every word;
- a ready handshake that blocks requests while a sweep runs.

Tag, valid and dirty arrays instantiate it so that invalidate-all costs DEPTH cycles and no controller logic.

---
 rtl/mp_ooo_sweep_sram_pkg.sv | 15 +
 rtl/mp_ooo_sweep_sram_if.sv | 32 +++
 rtl/mp_ooo_sweep_sram_core.sv | 32 +++
 rtl/mp_ooo_sweep_sram.sv | 97 +++++++++
 tb/tb_mp_ooo_sweep_sram.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mp_ooo_sweep_sram_pkg.sv
// rtl/mp_ooo_sweep_sram_pkg.sv - shared types and sizing helpers for the sweeping 1RW SRAM
package mp_ooo_sram_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    READY = 1'b1
  } sram_state_t;

  function automatic int mask_w(input int data_width, input int mask_gran);
    return data_width / mask_gran;
  endfunction

  localparam int DEFAULT_MASK_W = mask_w(24, 8);

endpackage

// File: rtl/mp_ooo_sweep_sram_if.sv
// rtl/mp_ooo_sweep_sram_if.sv - request/response bundle between a cache controller and the SRAM
interface mp_ooo_sweep_sram_if
  import mp_ooo_sram_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 4,
  parameter int MASK_GRAN  = 8
);

  localparam int MASK_W = mask_w(DATA_WIDTH, MASK_GRAN);

  logic                  csb;
  logic                  web;
  logic [MASK_W-1:0]     wmask;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  ready;
  logic                  flush;
  logic                  sweep_done;

  modport master (
    output csb, web, wmask, addr, din, flush,
    input  dout, ready, sweep_done
  );

  modport slave (
    input  csb, web, wmask, addr, din, flush,
    output dout, ready, sweep_done
  );

endinterface

// File: rtl/mp_ooo_sweep_sram_core.sv
// rtl/mp_ooo_sweep_sram_core.sv - plain 1RW storage with slice write mask and registered read
module mp_ooo_sram_core #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 4,
  parameter int MASK_GRAN  = 8,
  parameter int MASK_W     = DATA_WIDTH / MASK_GRAN
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [MASK_W-1:0]     wmask,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < MASK_W; i++) begin
      if (we && wmask[i]) begin
        mem[addr][i*MASK_GRAN +: MASK_GRAN] <= wdata[i*MASK_GRAN +: MASK_GRAN];
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mp_ooo_sweep_sram.sv
// rtl/mp_ooo_sweep_sram.sv - 1RW SRAM that writes INIT_VALUE everywhere after reset or flush
module mp_ooo_sweep_sram
  import mp_ooo_sram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 24,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    MASK_GRAN  = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  mp_ooo_sweep_sram_if.slave   bus
);

  localparam int MASK_W = mask_w(DATA_WIDTH, MASK_GRAN);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  if (DATA_WIDTH % MASK_GRAN != 0) begin : g_bad_gran
    $error("DATA_WIDTH must be a multiple of MASK_GRAN");
  end

  sram_state_t           state;
  logic [ADDR_WIDTH-1:0] sweep_cnt;
  logic                  sweep_done_q;
  logic                  rd_valid;

  logic                  sweeping;
  logic                  accept;
  logic                  core_we;
  logic                  core_re;
  logic [MASK_W-1:0]     core_mask;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic [DATA_WIDTH-1:0] core_rdata;

  assign sweeping = (state == SWEEP);
  assign accept   = !sweeping && !bus.csb;

  // The sweep owns the write port outright; requests are not even looked at.
  assign core_we    = sweeping || (accept && !bus.web);
  assign core_re    = accept && bus.web;
  assign core_mask  = sweeping ? {MASK_W{1'b1}} : bus.wmask;
  assign core_addr  = sweeping ? sweep_cnt : bus.addr;
  assign core_wdata = sweeping ? INIT_VALUE : bus.din;

  mp_ooo_sram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MASK_GRAN  (MASK_GRAN),
    .MASK_W     (MASK_W)
  ) u_core (
    .clk   (clk),
    .we    (core_we),
    .re    (core_re),
    .wmask (core_mask),
    .addr  (core_addr),
    .wdata (core_wdata),
    .rdata (core_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SWEEP;
      sweep_cnt    <= '0;
      sweep_done_q <= 1'b0;
      rd_valid     <= 1'b0;
    end else begin
      sweep_done_q <= 1'b0;
      case (state)
        SWEEP: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST_ADDR) begin
            state        <= READY;
            sweep_cnt    <= '0;
            sweep_done_q <= 1'b1;
          end
        end
        READY: begin
          if (core_re) begin
            rd_valid <= 1'b1;
          end
          if (bus.flush) begin
            state     <= SWEEP;
            sweep_cnt <= '0;
          end
        end
        default: state <= SWEEP;
      endcase
    end
  end

  // The storage read register has no reset, so dout is forced to zero until a read lands.
  assign bus.dout       = rd_valid ? core_rdata : '0;
  assign bus.ready      = (state == READY);
  assign bus.sweep_done = sweep_done_q;

endmodule

// File: tb/tb_mp_ooo_sweep_sram.sv
// tb/tb_mp_ooo_sweep_sram.sv - directed vector bench for mp_ooo_sweep_sram
module tb_mp_ooo_sweep_sram;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mp_ooo_sweep_sram_if #(.DATA_WIDTH(24), .ADDR_WIDTH(4), .MASK_GRAN(8)) bus ();

  mp_ooo_sweep_sram #(
    .DATA_WIDTH (24),
    .ADDR_WIDTH (4),
    .MASK_GRAN  (8),
    .INIT_VALUE (24'h000000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        csb;
    logic        web;
    logic [2:0]  wmask;
    logic [3:0]  addr;
    logic [23:0] din;
    logic [23:0] exp_dout;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.csb   = 1'b1;
    bus.web   = 1'b1;
    bus.wmask = 3'b000;
    bus.addr  = 4'd0;
    bus.din   = 24'h0;
    bus.flush = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [23:0] exp, input string name);
    bus.csb  = 1'b0;
    bus.web  = 1'b1;
    bus.addr = a;
    step();
    idle();
    check(name, {8'h0, bus.dout}, {8'h0, exp});
  endtask

  task automatic do_write(input logic [3:0] a, input logic [23:0] d, input logic [2:0] m);
    bus.csb   = 1'b0;
    bus.web   = 1'b0;
    bus.addr  = a;
    bus.din   = d;
    bus.wmask = m;
    step();
    idle();
  endtask

  // Expects the sweep to have just started before the first edge awaited here.
  task automatic wait_sweep(input string name);
    for (int i = 1; i <= 16; i++) begin
      step();
      check({name, "_ready"}, {31'h0, bus.ready}, {31'h0, (i == 16)});
      check({name, "_done"}, {31'h0, bus.sweep_done}, {31'h0, (i == 16)});
    end
    step();
    check({name, "_done_low"}, {31'h0, bus.sweep_done}, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();

    //               csb   web   mask    addr  din         exp_dout
    vecs[0]  = '{1'b0, 1'b0, 3'b111, 4'd5, 24'hABCDEF, 24'h000000};
    vecs[1]  = '{1'b0, 1'b1, 3'b000, 4'd5, 24'h000000, 24'hABCDEF};
    vecs[2]  = '{1'b1, 1'b1, 3'b000, 4'd0, 24'h000000, 24'hABCDEF};
    vecs[3]  = '{1'b1, 1'b0, 3'b111, 4'd5, 24'h999999, 24'hABCDEF};
    vecs[4]  = '{1'b1, 1'b1, 3'b000, 4'd0, 24'h000000, 24'hABCDEF};
    vecs[5]  = '{1'b0, 1'b0, 3'b010, 4'd5, 24'h112233, 24'hABCDEF};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 4'd5, 24'h000000, 24'hAB22EF};
    vecs[7]  = '{1'b0, 1'b0, 3'b000, 4'd3, 24'hFFFFFF, 24'hAB22EF};
    vecs[8]  = '{1'b0, 1'b1, 3'b000, 4'd3, 24'h000000, 24'h000000};
    vecs[9]  = '{1'b0, 1'b0, 3'b100, 4'd3, 24'h5A1234, 24'h000000};
    vecs[10] = '{1'b0, 1'b1, 3'b000, 4'd3, 24'h000000, 24'h5A0000};
    vecs[11] = '{1'b0, 1'b0, 3'b111, 4'd9, 24'h123456, 24'h5A0000};

    rst = 1'b1;
    #1;
    check("reset_ready", {31'h0, bus.ready}, 32'h0);
    check("reset_dout", {8'h0, bus.dout}, 32'h0);
    check("reset_done", {31'h0, bus.sweep_done}, 32'h0);
    step();
    step();
    step();
    rst = 1'b0;
    wait_sweep("init_sweep");

    for (int a = 0; a < 16; a++) begin
      do_read(4'(a), 24'h000000, "init_read");
    end

    for (int i = 0; i < 12; i++) begin
      bus.csb   = vecs[i].csb;
      bus.web   = vecs[i].web;
      bus.wmask = vecs[i].wmask;
      bus.addr  = vecs[i].addr;
      bus.din   = vecs[i].din;
      step();
      idle();
      check($sformatf("vec%0d_dout", i), {8'h0, bus.dout}, {8'h0, vecs[i].exp_dout});
    end

    // Read of addr 9 accepted in the same cycle as a flush.
    bus.csb   = 1'b0;
    bus.web   = 1'b1;
    bus.addr  = 4'd9;
    bus.flush = 1'b1;
    step();
    idle();
    check("flush_read_dout", {8'h0, bus.dout}, 32'h00123456);
    check("flush_ready", {31'h0, bus.ready}, 32'h0);
    for (int i = 1; i <= 15; i++) begin
      step();
      check("flush_sweep_ready", {31'h0, bus.ready}, 32'h0);
    end
    step();
    check("flush_done_ready", {31'h0, bus.ready}, 32'h1);
    check("flush_done_pulse", {31'h0, bus.sweep_done}, 32'h1);
    step();
    check("flush_done_low", {31'h0, bus.sweep_done}, 32'h0);
    do_read(4'd9, 24'h000000, "flush_read9");

    // Reset mid-sweep with the counter at 7.
    do_write(4'd12, 24'h777777, 3'b111);
    do_write(4'd5, 24'hABCDEF, 3'b111);
    do_read(4'd5, 24'hABCDEF, "pre_rst_read");
    bus.flush = 1'b1;
    step();
    idle();
    for (int i = 0; i < 7; i++) begin
      step();
    end
    rst = 1'b1;
    #1;
    check("midrst_dout", {8'h0, bus.dout}, 32'h0);
    check("midrst_ready", {31'h0, bus.ready}, 32'h0);
    step();
    rst = 1'b0;
    wait_sweep("midrst_sweep");
    do_read(4'd12, 24'h000000, "midrst_read12");
    do_read(4'd5, 24'h000000, "midrst_read5");

    // Writes hammered during a sweep must be dropped.
    bus.flush = 1'b1;
    step();
    idle();
    for (int i = 0; i < 16; i++) begin
      bus.csb   = 1'b0;
      bus.web   = 1'b0;
      bus.wmask = 3'b111;
      bus.addr  = 4'(i);
      bus.din   = 24'hFFFFFF;
      step();
      check("hammer_ready", {31'h0, bus.ready}, {31'h0, (i == 15)});
    end
    idle();
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a), 24'h000000, "hammer_read");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
